// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller.
// - DATA_WIDTH : core datapath width, default for address widths
// - ALIGN_MASK : low PC bits that must be zero for a legal fetch target
// - brc_state_e: controller state encoding
// - is_aligned : true when an address low field has no ALIGN_MASK bits set
package branch_redirect_ctrl_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRedirect = 2'd1,
    StDrain    = 2'd2
  } brc_state_e;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_perf_counter.sv
// Wrapping event counter.
// - clk   : core clock
// - clr_n : synchronous active-low clear
// - en    : increment enable
// - count : current value, wraps modulo 2^CNT_WIDTH
module perf_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] One = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + One;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Front-end sequencer for taken branches/jumps resolved in EX.
// Inputs : clk, rst_n (sync, active-low), ex_valid, ex_branch_req, ex_branch_res, ex_jump,
//          ex_target, if_redirect_ready
// Outputs: redirect_valid/redirect_pc (valid/ready to fetch), flush_if_id, flush_id_ex,
//          stall_ex, misalign_err (1-cycle pulse), busy, branch_cnt, taken_cnt
// All outputs come from flops or from the state register only.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DATA_WIDTH,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic                  ex_branch_req,
  input  logic                  ex_branch_res,
  input  logic                  ex_jump,
  input  logic [ADDR_WIDTH-1:0] ex_target,
  input  logic                  if_redirect_ready,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  stall_ex,
  output logic                  misalign_err,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  branch_cnt,
  output logic [CNT_WIDTH-1:0]  taken_cnt
);

  localparam logic [3:0] DrainInit = 4'(FLUSH_CYCLES - 1);

  brc_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [3:0]            drain_q, drain_d;
  logic                  misalign_q, misalign_d;

  logic idle;
  logic taken;
  logic branch_inc;

  assign idle       = (state_q == StIdle);
  assign taken      = ex_valid & (ex_jump | (ex_branch_req & ex_branch_res));
  // Wrong-path events outside IDLE must not touch the counters.
  assign branch_inc = idle & ex_valid & ex_branch_req;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drain_d    = drain_q;
    misalign_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (taken) begin
          if (is_aligned(ex_target[1:0])) begin
            pc_d    = ex_target;
            state_d = StRedirect;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      StRedirect: begin
        if (if_redirect_ready) begin
          if (FLUSH_CYCLES == 1) begin
            state_d = StIdle;
          end else begin
            drain_d = DrainInit;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (drain_q <= 4'd1) begin
          state_d = StIdle;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      drain_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drain_q    <= drain_d;
      misalign_q <= misalign_d;
    end
  end

  assign redirect_valid = (state_q == StRedirect);
  assign flush_if_id    = (state_q == StRedirect) | (state_q == StDrain);
  assign flush_id_ex    = (state_q == StRedirect);
  assign stall_ex       = (state_q == StRedirect);
  assign busy           = ~idle;
  assign redirect_pc    = pc_q;
  assign misalign_err   = misalign_q;

  perf_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_branch_cnt (
    .clk  (clk),
    .clr_n(rst_n),
    .en   (branch_inc),
    .count(branch_cnt)
  );

  perf_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_taken_cnt (
    .clk  (clk),
    .clr_n(rst_n),
    .en   (idle & taken),
    .count(taken_cnt)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

  typedef struct {
    logic        rst_n, v, b, res, j;
    logic [31:0] tgt;
    logic        rdy;
    logic        rv;
    logic [31:0] pc;
    logic        fi, fe, st, me, bz;
    logic [31:0] bc, tc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: default parameters
  logic        rst_n, ex_valid, ex_branch_req, ex_branch_res, ex_jump, rdy;
  logic [31:0] ex_target;
  logic        redirect_valid, flush_if_id, flush_id_ex, stall_ex, misalign_err, busy;
  logic [31:0] redirect_pc, branch_cnt, taken_cnt;

  // Second DUT: narrow counters, longer drain
  logic        w_rst_n, w_v, w_b, w_res, w_j, w_rdy;
  logic [31:0] w_tgt;
  logic        w_rv, w_fi, w_fe, w_st, w_me, w_bz;
  logic [31:0] w_pc;
  logic [3:0]  w_bc, w_tc;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  branch_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_branch_req(ex_branch_req),
    .ex_branch_res(ex_branch_res), .ex_jump(ex_jump), .ex_target(ex_target),
    .if_redirect_ready(rdy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .stall_ex(stall_ex),
    .misalign_err(misalign_err), .busy(busy), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  branch_redirect_ctrl #(
    .ADDR_WIDTH(32), .FLUSH_CYCLES(3), .CNT_WIDTH(4)
  ) dut_w (
    .clk(clk), .rst_n(w_rst_n), .ex_valid(w_v), .ex_branch_req(w_b),
    .ex_branch_res(w_res), .ex_jump(w_j), .ex_target(w_tgt),
    .if_redirect_ready(w_rdy), .redirect_valid(w_rv), .redirect_pc(w_pc),
    .flush_if_id(w_fi), .flush_id_ex(w_fe), .stall_ex(w_st),
    .misalign_err(w_me), .busy(w_bz), .branch_cnt(w_bc), .taken_cnt(w_tc)
  );

  function automatic vec_t mk(logic r, logic v, logic b, logic res, logic j, logic [31:0] tgt,
                              logic rd, logic rv, logic [31:0] pc, logic fi, logic fe,
                              logic st, logic me, logic bz, logic [31:0] bc, logic [31:0] tc);
    vec_t x;
    x.rst_n = r; x.v = v; x.b = b; x.res = res; x.j = j; x.tgt = tgt; x.rdy = rd;
    x.rv = rv; x.pc = pc; x.fi = fi; x.fe = fe; x.st = st; x.me = me; x.bz = bz;
    x.bc = bc; x.tc = tc;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic w_idle();
    w_v = 1'b0; w_b = 1'b0; w_res = 1'b0; w_j = 1'b0; w_tgt = '0; w_rdy = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // r v b res j tgt rdy | rv pc fi fe st me bz bc tc
    vecs.push_back(mk(0, 0, 0, 0, 0, 'h000, 0, 0, 'h000, 0, 0, 0, 0, 0, 0, 0)); // reset
    vecs.push_back(mk(1, 1, 1, 1, 0, 'h100, 0, 1, 'h100, 1, 1, 1, 0, 1, 1, 1)); // taken beq
    vecs.push_back(mk(1, 0, 0, 0, 0, 'h000, 1, 0, 'h100, 1, 0, 0, 0, 1, 1, 1)); // handshake
    vecs.push_back(mk(1, 0, 0, 0, 0, 'h000, 0, 0, 'h100, 0, 0, 0, 0, 0, 1, 1)); // idle
    vecs.push_back(mk(1, 1, 1, 0, 0, 'h300, 0, 0, 'h100, 0, 0, 0, 0, 0, 2, 1)); // not taken
    vecs.push_back(mk(1, 0, 0, 0, 0, 'h000, 0, 0, 'h100, 0, 0, 0, 0, 0, 2, 1));
    vecs.push_back(mk(1, 1, 0, 0, 1, 'h200, 1, 1, 'h200, 1, 1, 1, 0, 1, 2, 2)); // jal, rdy ignored
    vecs.push_back(mk(1, 1, 1, 1, 0, 'h400, 0, 1, 'h200, 1, 1, 1, 0, 1, 2, 2)); // wrong path
    vecs.push_back(mk(1, 0, 0, 0, 0, 'h000, 0, 1, 'h200, 1, 1, 1, 0, 1, 2, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 'h000, 0, 1, 'h200, 1, 1, 1, 0, 1, 2, 2));
    vecs.push_back(mk(1, 1, 1, 1, 0, 'h400, 1, 0, 'h200, 1, 0, 0, 0, 1, 2, 2)); // accept
    vecs.push_back(mk(1, 1, 1, 1, 0, 'h500, 0, 0, 'h200, 0, 0, 0, 0, 0, 2, 2)); // taken in DRAIN
    vecs.push_back(mk(1, 1, 0, 0, 1, 'h102, 0, 0, 'h200, 0, 0, 0, 1, 0, 2, 3)); // misaligned jalr
    vecs.push_back(mk(1, 0, 0, 0, 0, 'h000, 0, 0, 'h200, 0, 0, 0, 0, 0, 2, 3));
    vecs.push_back(mk(1, 1, 1, 1, 0, 'h101, 0, 0, 'h200, 0, 0, 0, 1, 0, 3, 4)); // misaligned beq
    vecs.push_back(mk(1, 0, 0, 0, 0, 'h000, 0, 0, 'h200, 0, 0, 0, 0, 0, 3, 4));
    vecs.push_back(mk(1, 0, 1, 1, 1, 'h600, 0, 0, 'h200, 0, 0, 0, 0, 0, 3, 4)); // ex_valid=0
    vecs.push_back(mk(1, 1, 0, 0, 1, 'h700, 0, 1, 'h700, 1, 1, 1, 0, 1, 3, 5)); // enter REDIRECT
    vecs.push_back(mk(0, 0, 0, 0, 0, 'h000, 0, 0, 'h000, 0, 0, 0, 0, 0, 0, 0)); // reset mid-op
    vecs.push_back(mk(1, 1, 1, 1, 0, 'h800, 1, 1, 'h800, 1, 1, 1, 0, 1, 1, 1)); // taken at once
    vecs.push_back(mk(1, 0, 0, 0, 0, 'h000, 1, 0, 'h800, 1, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 1, 'h900, 0, 0, 'h800, 0, 0, 0, 0, 0, 1, 1)); // in DRAIN
    vecs.push_back(mk(1, 1, 0, 0, 1, 'h900, 0, 1, 'h900, 1, 1, 1, 0, 1, 1, 2)); // spacing 3
    vecs.push_back(mk(1, 0, 0, 0, 0, 'h000, 1, 0, 'h900, 1, 0, 0, 0, 1, 1, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 'h000, 0, 0, 'h900, 0, 0, 0, 0, 0, 1, 2));

    w_idle();
    w_rst_n = 1'b0;
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; ex_valid = vecs[i].v; ex_branch_req = vecs[i].b;
      ex_branch_res = vecs[i].res; ex_jump = vecs[i].j; ex_target = vecs[i].tgt;
      rdy = vecs[i].rdy;
      step();
      w_rst_n = 1'b1;
      chk($sformatf("v%0d redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].rv));
      chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].pc);
      chk($sformatf("v%0d flush_if_id", i), 32'(flush_if_id), 32'(vecs[i].fi));
      chk($sformatf("v%0d flush_id_ex", i), 32'(flush_id_ex), 32'(vecs[i].fe));
      chk($sformatf("v%0d stall_ex", i), 32'(stall_ex), 32'(vecs[i].st));
      chk($sformatf("v%0d misalign_err", i), 32'(misalign_err), 32'(vecs[i].me));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].bz));
      chk($sformatf("v%0d branch_cnt", i), branch_cnt, vecs[i].bc);
      chk($sformatf("v%0d taken_cnt", i), taken_cnt, vecs[i].tc);
    end

    // 4-bit counters: 16 misaligned taken branches wrap both counters to 0
    chk("w reset taken_cnt", 32'(w_tc), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      w_v = 1'b1; w_b = 1'b1; w_res = 1'b1; w_tgt = 32'h2;
      step();
      if (i == 15) begin
        chk("w taken_cnt 15", 32'(w_tc), 32'd15);
        chk("w branch_cnt 15", 32'(w_bc), 32'd15);
        chk("w misalign 15", 32'(w_me), 32'd1);
        chk("w busy 15", 32'(w_bz), 32'd0);
      end
    end
    chk("w taken_cnt wrap", 32'(w_tc), 32'd0);
    chk("w branch_cnt wrap", 32'(w_bc), 32'd0);
    w_idle();
    step();
    chk("w misalign clear", 32'(w_me), 32'd0);

    // FLUSH_CYCLES=3: flush_if_id for handshake cycle plus two drain cycles
    w_v = 1'b1; w_j = 1'b1; w_tgt = 32'h40;
    step();
    chk("w redirect_valid", 32'(w_rv), 32'd1);
    chk("w redirect_pc", w_pc, 32'h40);
    w_idle();
    w_rdy = 1'b1;
    step();
    chk("w drain1 flush_if_id", 32'(w_fi), 32'd1);
    chk("w drain1 redirect_valid", 32'(w_rv), 32'd0);
    chk("w drain1 flush_id_ex", 32'(w_fe), 32'd0);
    step();
    chk("w drain2 flush_if_id", 32'(w_fi), 32'd1);
    chk("w drain2 busy", 32'(w_bz), 32'd1);
    step();
    chk("w idle flush_if_id", 32'(w_fi), 32'd0);
    chk("w idle busy", 32'(w_bz), 32'd0);
    chk("w jal taken_cnt", 32'(w_tc), 32'd1);
    chk("w jal branch_cnt", 32'(w_bc), 32'd0);
    chk("w stall_ex idle", 32'(w_st), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
